// File: rtl/fdc_seek_ctrl.sv
// Purpose : floppy head positioner that issues STEP/DIR pulses for seek and restore commands.
// Latency : command accepted on the strobe edge; first STEP about 2 clk later; done pulses once per command.
// Backpress: no queueing; strobes are accepted only while idle and are dropped while busy.
//
// Ports:
//   clk, reset_n             : single clock, asynchronous active-low reset
//   cmd_seek / cmd_restore   : one-cycle command strobes (restore wins if both)
//   target, rate, settle_en  : command operands, latched on the accepted strobe
//   tr00                     : raw track-0 sense from the drive (synchronised here)
//   busy, done, err          : command status
//   cur_track                : head position register
//   step, dir                : drive step pulse and direction (1 = step in)
//
// TICKS_PER_MS scales the step-rate table (ticks per millisecond of rate);
// it stays at 1000 for a 1 us tick and exists so short simulations are possible.

module fdc_seek_ctrl #(
    parameter int TICK_DIV     = 16,
    parameter int PULSE_US     = 4,
    parameter int SETTLE_US    = 15000,
    parameter int MAX_RESTORE  = 255,
    parameter int TICKS_PER_MS = 1000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       cmd_seek,
    input  logic       cmd_restore,
    input  logic [7:0] target,
    input  logic [1:0] rate,
    input  logic       settle_en,
    input  logic       tr00,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [7:0] cur_track,
    output logic       step,
    output logic       dir
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    localparam logic [14:0] PULSE_LEN  = 15'(PULSE_US);
    localparam logic [14:0] SETTLE_LEN = 15'(SETTLE_US);
    localparam logic [7:0]  RESTORE_LIM = 8'(MAX_RESTORE);

    // Last tick index of the inter-pulse gap: pulse + gap = one rate period.
    localparam logic [14:0] IVL_LAST_0 = 15'(6  * TICKS_PER_MS - PULSE_US - 1);
    localparam logic [14:0] IVL_LAST_1 = 15'(12 * TICKS_PER_MS - PULSE_US - 1);
    localparam logic [14:0] IVL_LAST_2 = 15'(20 * TICKS_PER_MS - PULSE_US - 1);
    localparam logic [14:0] IVL_LAST_3 = 15'(30 * TICKS_PER_MS - PULSE_US - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_DECIDE   = 3'd1,
        S_PULSE    = 3'd2,
        S_INTERVAL = 3'd3,
        S_SETTLE   = 3'd4,
        S_FINISH   = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [14:0] cnt_q, cnt_d;
    logic        tr00_meta_q, tr00_sync_q;
    logic        rdy_q;
    logic [7:0]  target_q, target_d;
    logic [1:0]  rate_q, rate_d;
    logic        settle_q, settle_d;
    logic        restore_q, restore_d;
    logic        err_q, err_d;
    logic [7:0]  step_cnt_q, step_cnt_d;
    logic [7:0]  cur_track_q, cur_track_d;
    logic        dir_q, dir_d;

    logic        tick;
    logic        accept;
    logic        decide_dir;
    logic [14:0] ivl_last;

    // Free-running 1 us time base.
    assign tick    = (presc_q == PRESC_LAST);
    assign presc_d = tick ? '0 : presc_q + PW'(1);

    // rdy_q keeps the first edge after reset release from accepting a command.
    assign accept = (state_q == S_IDLE) && rdy_q && (cmd_seek || cmd_restore);

    always_comb begin
        ivl_last = IVL_LAST_0;
        case (rate_q)
            2'd0:    ivl_last = IVL_LAST_0;
            2'd1:    ivl_last = IVL_LAST_1;
            2'd2:    ivl_last = IVL_LAST_2;
            default: ivl_last = IVL_LAST_3;
        endcase
    end

    assign decide_dir = restore_q ? 1'b0 : (target_q > cur_track_q);

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- next-state logic ----------------
    // PULSE and SETTLE leave the cycle after their last tick; INTERVAL leaves
    // on its last tick. With the one-cycle DECIDE in between, every pulse
    // after the first starts on the same prescaler phase, so the width is
    // exactly PULSE_US ticks and the rising-edge period exactly one rate.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) state_d = S_DECIDE;
            end
            S_DECIDE: begin
                if (restore_q) begin
                    if (tr00_sync_q)
                        state_d = settle_q ? S_SETTLE : S_FINISH;
                    else if (step_cnt_q == RESTORE_LIM)
                        state_d = S_FINISH;
                    else
                        state_d = S_PULSE;
                end else begin
                    if (cur_track_q == target_q)
                        state_d = settle_q ? S_SETTLE : S_FINISH;
                    else
                        state_d = S_PULSE;
                end
            end
            S_PULSE: begin
                if (cnt_q == PULSE_LEN) state_d = S_INTERVAL;
            end
            S_INTERVAL: begin
                if (tick && (cnt_q == ivl_last)) state_d = S_DECIDE;
            end
            S_SETTLE: begin
                if (cnt_q == SETTLE_LEN) state_d = S_FINISH;
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ---------------- output logic ----------------
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        step = 1'b0;
        case (state_q)
            S_DECIDE, S_INTERVAL, S_SETTLE: busy = 1'b1;
            S_PULSE: begin
                busy = 1'b1;
                step = 1'b1;
            end
            S_FINISH: done = 1'b1;
            default: ;
        endcase
    end

    assign err       = err_q;
    assign cur_track = cur_track_q;
    assign dir       = dir_q;

    // ---------------- datapath ----------------
    // Tick counter restarts on every state change.
    always_comb begin
        if (state_d != state_q)
            cnt_d = '0;
        else if (tick)
            cnt_d = cnt_q + 15'd1;
        else
            cnt_d = cnt_q;
    end

    always_comb begin
        target_d    = target_q;
        rate_d      = rate_q;
        settle_d    = settle_q;
        restore_d   = restore_q;
        err_d       = err_q;
        step_cnt_d  = step_cnt_q;
        cur_track_d = cur_track_q;
        dir_d       = dir_q;

        if (accept) begin
            target_d   = target;
            rate_d     = rate;
            settle_d   = settle_en;
            restore_d  = cmd_restore;
            err_d      = 1'b0;
            step_cnt_d = '0;
        end

        if (state_q == S_DECIDE) begin
            if (state_d == S_PULSE) begin
                // Head position moves on the edge that raises STEP; dir is
                // already valid from this edge and stays put until next DECIDE.
                dir_d = decide_dir;
                if (decide_dir) begin
                    if (cur_track_q != 8'hFF) cur_track_d = cur_track_q + 8'd1;
                end else begin
                    if (cur_track_q != 8'h00) cur_track_d = cur_track_q - 8'd1;
                end
                if (restore_q) step_cnt_d = step_cnt_q + 8'd1;
            end else if (restore_q) begin
                if (tr00_sync_q)
                    cur_track_d = '0;
                else
                    err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc_q     <= '0;
            cnt_q       <= '0;
            tr00_meta_q <= 1'b0;
            tr00_sync_q <= 1'b0;
            rdy_q       <= 1'b0;
            target_q    <= '0;
            rate_q      <= '0;
            settle_q    <= 1'b0;
            restore_q   <= 1'b0;
            err_q       <= 1'b0;
            step_cnt_q  <= '0;
            cur_track_q <= '0;
            dir_q       <= 1'b0;
        end else begin
            presc_q     <= presc_d;
            cnt_q       <= cnt_d;
            tr00_meta_q <= tr00;
            tr00_sync_q <= tr00_meta_q;
            rdy_q       <= 1'b1;
            target_q    <= target_d;
            rate_q      <= rate_d;
            settle_q    <= settle_d;
            restore_q   <= restore_d;
            err_q       <= err_d;
            step_cnt_q  <= step_cnt_d;
            cur_track_q <= cur_track_d;
            dir_q       <= dir_d;
        end
    end

endmodule

// File: tb/tb_fdc_seek_ctrl.sv
// Purpose : self-checking bench for fdc_seek_ctrl against a drive/head model.
// Latency : commands are awaited with bounded cycle budgets.
// Backpress: exercises strobes while busy (must be ignored).

module tb_fdc_seek_ctrl;

    localparam int TD   = 2;
    localparam int PUS  = 4;
    localparam int SUS  = 40;
    localparam int MAXR = 255;
    localparam int TPM  = 4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       cmd_seek = 1'b0;
    logic       cmd_restore = 1'b0;
    logic [7:0] target = 8'd0;
    logic [1:0] rate = 2'd0;
    logic       settle_en = 1'b0;
    logic       tr00;
    logic       busy, done, err, step, dir;
    logic [7:0] cur_track;

    fdc_seek_ctrl #(
        .TICK_DIV(TD), .PULSE_US(PUS), .SETTLE_US(SUS),
        .MAX_RESTORE(MAXR), .TICKS_PER_MS(TPM)
    ) dut (
        .clk(clk), .reset_n(reset_n), .cmd_seek(cmd_seek), .cmd_restore(cmd_restore),
        .target(target), .rate(rate), .settle_en(settle_en), .tr00(tr00),
        .busy(busy), .done(done), .err(err), .cur_track(cur_track),
        .step(step), .dir(dir)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input longint obs, input longint exp, input longint tol = 0);
        longint d;
        checks++;
        d = (obs > exp) ? obs - exp : exp - obs;
        if (d > tol) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d (+/-%0d)", tag, obs, exp, tol);
        end
    endtask

    function automatic int rate_ms(input logic [1:0] r);
        case (r)
            2'd0:    return 6;
            2'd1:    return 12;
            2'd2:    return 20;
            default: return 30;
        endcase
    endfunction

    // Drive model: physical head position follows STEP edges; tr00 reflects it.
    int   cyc = 0;
    bit   mon_en = 1'b0;
    bit   tr00_stuck = 1'b0;
    logic step_prev = 1'b0;
    logic dir_at_rise = 1'b0;
    int   phys = 0;
    int   pulses = 0;
    int   done_cnt = 0;
    int   rise_cyc = 0;
    int   exp_period = 0;
    int   cmd_cyc = 0;

    assign tr00 = tr00_stuck ? 1'b0 : (phys == 0);

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (mon_en) begin
            if (done) done_cnt++;
            if (step && !step_prev) begin
                pulses++;
                dir_at_rise = dir;
                if (pulses >= 2)
                    chk("step_period", cyc - rise_cyc, exp_period, (pulses == 2) ? TD - 1 : 0);
                rise_cyc = cyc;
                if (dir) phys = (phys < 255) ? phys + 1 : phys;
                else     phys = (phys > 0) ? phys - 1 : 0;
            end
            if (!step && step_prev) begin
                chk("step_width", cyc - rise_cyc, TD * PUS, (pulses == 1) ? TD - 1 : 0);
                chk("dir_hold", dir, dir_at_rise);
            end
        end
        step_prev = step;
    end

    task automatic strobe(input bit s, input bit r, input logic [7:0] tgt, input logic [1:0] rt, input bit se);
        @(negedge clk);
        cmd_seek = s; cmd_restore = r; target = tgt; rate = rt; settle_en = se;
        @(negedge clk);
        cmd_seek = 1'b0; cmd_restore = 1'b0;
        target = 8'($urandom); rate = 2'($urandom); settle_en = 1'($urandom);
    endtask

    task automatic issue(input bit s, input bit r, input logic [7:0] tgt, input logic [1:0] rt, input bit se);
        @(negedge clk);
        pulses = 0; done_cnt = 0;
        exp_period = rate_ms(rt) * TPM * TD;
        cmd_seek = s; cmd_restore = r; target = tgt; rate = rt; settle_en = se;
        @(negedge clk);
        cmd_seek = 1'b0; cmd_restore = 1'b0;
        target = 8'($urandom); rate = 2'($urandom); settle_en = 1'($urandom);
        cmd_cyc = cyc;
        chk("busy_on_accept", busy, 1);
        chk("err_clear_on_accept", err, 0);
    endtask

    task automatic wait_done(input int limit, output int dcyc);
        int n;
        n = 0;
        @(negedge clk);
        while (!done && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", done, 1);
        chk("busy_low_at_done", busy, 0);
        dcyc = cyc;
        @(negedge clk);
        chk("one_done_pulse", done_cnt, 1);
    endtask

    initial begin
        int dcyc, n, tgt, start, exp_track;

        // Reset values.
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_step", step, 0);
        chk("rst_dir", dir, 0);
        chk("rst_track", cur_track, 0);

        // First edge after release must not accept a command.
        mon_en = 1'b1;
        reset_n = 1'b1; cmd_seek = 1'b1; target = 8'd1;
        @(negedge clk);
        cmd_seek = 1'b0;
        @(negedge clk);
        chk("first_edge_ignored", busy, 0);

        // Seek 0 -> 3 at the fastest rate.
        issue(1'b1, 1'b0, 8'd3, 2'd0, 1'b0);
        wait_done(5000, dcyc);
        chk("seek3_pulses", pulses, 3);
        chk("seek3_track", cur_track, 3);
        chk("seek3_dir", dir, 1);
        chk("seek3_phys", phys, 3);

        // Both strobes together: restore wins.
        issue(1'b1, 1'b1, 8'd200, 2'd0, 1'b0);
        wait_done(5000, dcyc);
        chk("both_pulses", pulses, 3);
        chk("both_track", cur_track, 0);
        chk("both_dir", dir, 0);
        chk("both_err", err, 0);

        // Seek to 5 with a stray seek strobe while busy.
        issue(1'b1, 1'b0, 8'd5, 2'd1, 1'b0);
        repeat (20) @(negedge clk);
        strobe(1'b1, 1'b0, 8'd9, 2'd3, 1'b1);
        wait_done(5000, dcyc);
        chk("busy_strobe_pulses", pulses, 5);
        chk("busy_strobe_track", cur_track, 5);

        // Restore from 5: tr00 rises once the head reaches track 0.
        issue(1'b0, 1'b1, 8'd0, 2'd0, 1'b0);
        wait_done(5000, dcyc);
        chk("restore5_pulses", pulses, 5);
        chk("restore5_track", cur_track, 0);
        chk("restore5_dir", dir, 0);
        chk("restore5_err", err, 0);

        // Seek to current track with settle: no pulse, done after SETTLE_US ticks.
        issue(1'b1, 1'b0, 8'd0, 2'd2, 1'b1);
        wait_done(5000, dcyc);
        chk("settle_pulses", pulses, 0);
        chk("settle_delay", dcyc - cmd_cyc, TD * SUS, TD + 2);

        // Random seeks against the head model.
        exp_track = 0;
        for (int i = 0; i < 8; i++) begin
            start = exp_track;
            tgt = exp_track + int'($urandom_range(16)) - 8;
            if (tgt < 0) tgt = 0;
            if (tgt > 240) tgt = 240;
            issue(1'b1, 1'b0, 8'(tgt), 2'($urandom), 1'($urandom));
            wait_done(5000, dcyc);
            chk("rnd_pulses", pulses, (tgt > start) ? tgt - start : start - tgt);
            chk("rnd_track", cur_track, tgt);
            chk("rnd_phys", phys, tgt);
            chk("rnd_err", err, 0);
            if (tgt != start) chk("rnd_dir", dir, (tgt > start) ? 1 : 0);
            exp_track = tgt;
        end

        // Restore with tr00 stuck low: gives up after MAXR steps.
        tr00_stuck = 1'b1;
        issue(1'b0, 1'b1, 8'd0, 2'd0, 1'b0);
        wait_done(20000, dcyc);
        chk("stuck_pulses", pulses, MAXR);
        chk("stuck_err", err, 1);
        chk("stuck_track", cur_track, 0);
        repeat (3) @(negedge clk);
        chk("stuck_err_sticky", err, 1);
        tr00_stuck = 1'b0;

        // Next seek clears err (checked on accept inside issue).
        issue(1'b1, 1'b0, 8'd2, 2'd0, 1'b0);
        wait_done(5000, dcyc);
        chk("after_err_track", cur_track, 2);
        chk("after_err_err", err, 0);

        // Reset asserted in the middle of a step pulse.
        issue(1'b1, 1'b0, 8'd8, 2'd0, 1'b0);
        n = 0;
        while (!step && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("midpulse_step_seen", step, 1);
        mon_en = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk("midrst_step", step, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_err", err, 0);
        chk("midrst_dir", dir, 0);
        chk("midrst_track", cur_track, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fdc_seek_ctrl.md
FDC_SEEK_CTRL -- requirements
Module: fdc_seek_ctrl

Interface
REQ-001 Parameter TICK_DIV, default 16, number of clk cycles per 1 us time-base tick (16 for the 16 MHz FDC clock).
REQ-002 Parameter PULSE_US, default 4, STEP pulse width in us.
REQ-003 Parameter SETTLE_US, default 15000, head-settle delay in us.
REQ-004 Parameter MAX_RESTORE, default 255, step-out limit before restore error.
REQ-005 clk  in  1  single clock; all state on its rising edge.
REQ-006 reset_n  in  1  reset, asynchronous, active-low.
REQ-007 cmd_seek  in  1  one-cycle strobe: seek to target.
REQ-008 cmd_restore  in  1  one-cycle strobe: step out to track 0.
REQ-009 target  in  8  destination track, sampled on the cmd_seek cycle.
REQ-010 rate  in  2  step interval: 00=6 ms, 01=12 ms, 10=20 ms, 11=30 ms; sampled on command.
REQ-011 settle_en  in  1  apply the settle delay after the last step; sampled on command.
REQ-012 tr00  in  1  asynchronous drive track-0 sense, active-high.
REQ-013 busy  out  1  command in progress.
REQ-014 done  out  1  one-cycle completion pulse.
REQ-015 err  out  1  sticky restore failure; cleared by the next accepted command.
REQ-016 cur_track  out  8  current head position register.
REQ-017 step  out  1  step pulse to drive, active-high.
REQ-018 dir  out  1  1 = step in (track+1), 0 = step out.

Function
REQ-019 tr00 passes through a 2-FF synchroniser; only the synchronised value is used.
REQ-020 A free-running prescaler produces a one-clk tick every TICK_DIV clk; all delays count ticks with a 15-bit counter.
REQ-021 FSM states: IDLE, DECIDE, PULSE, INTERVAL, SETTLE, FINISH.
REQ-022 IDLE: cmd_restore takes priority over cmd_seek when both arrive in one cycle; accept -> latch operands, clear err, busy=1, go to DECIDE next cycle.
REQ-023 Strobes during busy=1 are ignored, with no effect on latched operands.
REQ-024 DECIDE (seek): cur_track==target -> SETTLE if settle_en, else FINISH; otherwise dir=(target>cur_track) and go to PULSE.
REQ-025 DECIDE (restore): tr00=1 -> cur_track<=0, then SETTLE/FINISH as for seek; step count==MAX_RESTORE -> err=1, go to FINISH; otherwise dir=0, go to PULSE.
REQ-026 dir is set in DECIDE at least one clk before step rises and holds until the FSM next reaches DECIDE.
REQ-027 PULSE: step=1 for PULSE_US ticks; on entry cur_track steps by 1 in the dir direction. Seek saturates at 0 and 255; restore does not decrement below 0.
REQ-028 INTERVAL: step=0, wait (rate_ms*1000 - PULSE_US) ticks, then DECIDE; the pulse rising-edge period equals the selected rate.
REQ-029 Restore counts issued steps (8-bit) to check against MAX_RESTORE.
REQ-030 SETTLE: wait SETTLE_US ticks, then FINISH.
REQ-031 FINISH: done=1 for exactly one clk, busy=0 in the same cycle, then IDLE; a new command is accepted the following cycle.
REQ-032 Tick counts start at the tick after state entry; latency jitter is at most 1 tick.

Reset
REQ-033 Asserting reset_n=0 at any time, including mid-pulse, immediately forces: IDLE, step=0, dir=0, busy=0, done=0, err=0, cur_track=0, prescaler, counters and synchroniser all zero.
REQ-034 After release, the first command is accepted no earlier than the second clk edge.

Verification
REQ-035 Seek from 0 to target=3, rate=00, settle_en=0 -> 3 step pulses, each 64 clk wide, rising edges 96000 clk apart, dir=1, cur_track=3, one done pulse.
REQ-036 Restore with tr00 rising after the 5th pulse, starting from cur_track=5 -> 5 pulses, dir=0, cur_track=0, err=0.
REQ-037 Restore with tr00 held at 0 -> exactly 255 pulses, then err=1 and done; the next cmd_seek clears err.
REQ-038 Seek to target equal to cur_track with settle_en=1 -> no pulse; done arrives 15000 ticks (240000 clk) after the command, within 1 tick.
REQ-039 cmd_seek and cmd_restore in the same cycle -> restore executes. A cmd_seek during busy -> ignored.
REQ-040 reset_n pulsed low mid-PULSE -> step drops asynchronously, and all outputs read their reset values.
